// File: rtl/i2s_rx_master_ctrl.sv
// I2S master receive controller: generates SCK and WS for an external
// codec, deserialises SD into left/right samples and hands each stereo
// frame downstream over a valid/ready handshake.
module i2s_rx_master_ctrl #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              sd_i,
  output logic              sck_o,
  output logic              ws_o,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovr_o,
  output logic              busy_o
);

  localparam int BC_W  = $clog2(2 * SLOT_W);
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0]  CNT_LAST = BC_W'(2 * SLOT_W - 1);
  localparam logic [BC_W-1:0]  WS_LO    = BC_W'(SLOT_W - 1);
  localparam logic [BC_W-1:0]  WS_HI    = BC_W'(2 * SLOT_W - 2);
  localparam logic [BC_W-1:0]  L_LAST   = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0]  R_FIRST  = BC_W'(SLOT_W);
  localparam logic [BC_W-1:0]  R_LAST   = BC_W'(SLOT_W + DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                sck_q, sck_d;
  logic                ws_q, ws_d;
  logic                first_q, first_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   left_sh_q, left_sh_d;
  logic [DATA_W-1:0]   right_sh_q, right_sh_d;
  logic [DATA_W-1:0]   left_q, left_d;
  logic [DATA_W-1:0]   right_q, right_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic                term;
  logic                rise;
  logic                fall;
  logic                wrap;
  logic                frame_done;
  logic                publish;
  logic [BC_W-1:0]     bit_nxt;
  logic [DATA_W-1:0]   left_nxt;
  logic [DATA_W-1:0]   right_nxt;

  // The first terminal count after leaving IDLE only extends the low half,
  // so the codec sees a full SCK period of settled low clock before the
  // first rising edge.
  assign term       = (state_q != IDLE) && (div_q == DIV_LAST);
  assign rise       = term && !sck_q && !first_q;
  assign fall       = term && sck_q;
  assign bit_nxt    = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
  assign wrap       = fall && (bit_cnt_q == CNT_LAST);
  assign frame_done = rise && (bit_cnt_q == R_LAST);
  assign publish    = frame_done && ((state_q == RUN) || (state_q == STOP));
  assign left_nxt   = (left_sh_q << 1) | DATA_W'(sd_i);
  assign right_nxt  = (right_sh_q << 1) | DATA_W'(sd_i);

  // Sequencer: SYNC discards one frame, STOP always finishes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en_i) state_d = SYNC;
      SYNC: begin
        if (!en_i)     state_d = STOP;
        else if (wrap) state_d = RUN;
      end
      RUN:  if (!en_i) state_d = STOP;
      STOP: begin
        if (en_i)      state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clock generation, bit counting, capture and the output handshake.
  always_comb begin
    div_d      = div_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    first_d    = first_q;
    bit_cnt_d  = bit_cnt_q;
    left_sh_d  = left_sh_q;
    right_sh_d = right_sh_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    ovr_d      = 1'b0;

    if (state_q == IDLE) begin
      div_d      = '0;
      sck_d      = 1'b0;
      ws_d       = 1'b0;
      first_d    = 1'b1;
      bit_cnt_d  = '0;
      left_sh_d  = '0;
      right_sh_d = '0;
    end else begin
      div_d = term ? '0 : div_q + 1'b1;
      if (term && first_q) begin
        first_d = 1'b0;
      end else if (term) begin
        sck_d = !sck_q;
      end
      if (fall) begin
        bit_cnt_d = bit_nxt;
        ws_d      = (bit_nxt >= WS_LO) && (bit_nxt <= WS_HI);
      end
      if (rise) begin
        if (bit_cnt_q <= L_LAST) begin
          left_sh_d = left_nxt;
        end
        if ((bit_cnt_q >= R_FIRST) && (bit_cnt_q <= R_LAST)) begin
          right_sh_d = right_nxt;
        end
      end
    end

    if (publish) begin
      left_d  = left_sh_q;
      right_d = right_nxt;
      valid_d = 1'b1;
      ovr_d   = valid_q && !ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      first_q    <= 1'b1;
      bit_cnt_q  <= '0;
      left_sh_q  <= '0;
      right_sh_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      first_q    <= first_d;
      bit_cnt_q  <= bit_cnt_d;
      left_sh_q  <= left_sh_d;
      right_sh_q <= right_sh_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sck_o   = sck_q;
  assign ws_o    = ws_q;
  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_rx_master_ctrl.sv
// Scoreboard bench for i2s_rx_master_ctrl: a codec model feeds SD from the
// observed SCK/WS, stimulus pushes expected frames, monitors pop on accept.
module tb_i2s_rx_master_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  // Instance 1: 24-bit data, 32-bit slots, divide by 4
  logic        en1, sd1 = 1'b0, ready1, sck1, ws1, valid1, ovr1, busy1;
  logic [23:0] left1, right1;
  // Instance 2: 16-bit data filling 16-bit slots, divide by 2
  logic        en2, sd2 = 1'b0, ready2, sck2, ws2, valid2, ovr2, busy2;
  logic [15:0] left2, right2;

  logic [47:0] sb1[$];
  logic [31:0] sb2[$];
  int          acc1[$];
  int          ovrCnt1 = 0;
  int          ovrCnt2 = 0;
  logic [23:0] curL1 = 24'hFFFFFF, curR1 = 24'hFFFFFF;
  logic [15:0] curL2 = 16'hFFFF, curR2 = 16'hFFFF;
  int          wsRise1, wsFall1;

  i2s_rx_master_ctrl #(.DATA_W(24), .SLOT_W(32), .CLK_DIV(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .sd_i(sd1), .sck_o(sck1),
    .ws_o(ws1), .left_o(left1), .right_o(right1), .valid_o(valid1),
    .ready_i(ready1), .ovr_o(ovr1), .busy_o(busy1)
  );

  i2s_rx_master_ctrl #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .sd_i(sd2), .sck_o(sck2),
    .ws_o(ws2), .left_o(left2), .right_o(right2), .valid_o(valid2),
    .ready_i(ready2), .ovr_o(ovr2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // sel: 0=sck1 1=ws1 2=busy1 3=valid1 4=ws2 5=valid2
  task automatic waitSig(input int sel, input logic lvl, input int budget, input string name);
    logic cur;
    bit   hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       cur = sck1;
        1:       cur = ws1;
        2:       cur = busy1;
        3:       cur = valid1;
        4:       cur = ws2;
        default: cur = valid2;
      endcase
      if (cur == lvl) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got timeout after %0d cycles expected level %0b", name, budget, lvl);
    end
  endtask

  // Waits for the next left-slot start of instance 1 and loads that frame.
  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input bit pub);
    waitSig(1, 1'b1, 600, "ws1 rise");
    wsRise1 = cyc;
    waitSig(1, 1'b0, 600, "ws1 fall");
    wsFall1 = cyc;
    #2;
    curL1 = l;
    curR1 = r;
    if (pub) sb1.push_back({l, r});
  endtask

  task automatic applyStimulus2(input logic [15:0] l, input logic [15:0] r, input bit pub);
    waitSig(4, 1'b1, 200, "ws2 rise");
    waitSig(4, 1'b0, 200, "ws2 fall");
    #2;
    curL2 = l;
    curR2 = r;
    if (pub) sb2.push_back({l, r});
  endtask

  task automatic checkAllZero1(input string tag);
    checkOutput({tag, " sck"}, sck1, 0);
    checkOutput({tag, " ws"}, ws1, 0);
    checkOutput({tag, " left"}, left1, 0);
    checkOutput({tag, " right"}, right1, 0);
    checkOutput({tag, " valid"}, valid1, 0);
    checkOutput({tag, " ovr"}, ovr1, 0);
    checkOutput({tag, " busy"}, busy1, 0);
  endtask

  // Codec 1: on each SCK fall drive the next bit; a WS change restarts at MSB.
  int   pos1 = 100;
  logic chan1 = 1'b0;
  logic prevSck1 = 1'b0;
  always @(negedge clk) begin : codec1
    logic [23:0] w;
    if (prevSck1 && !sck1) begin
      w   = chan1 ? curR1 : curL1;
      sd1 = (pos1 < 24) ? w[5'(23 - pos1)] : 1'b1;
      if (ws1 != chan1) begin
        chan1 = ws1;
        pos1  = 0;
      end else begin
        pos1++;
      end
    end
    prevSck1 = sck1;
  end

  int   pos2 = 100;
  logic chan2 = 1'b0;
  logic prevSck2 = 1'b0;
  always @(negedge clk) begin : codec2
    logic [15:0] w;
    if (prevSck2 && !sck2) begin
      w   = chan2 ? curR2 : curL2;
      sd2 = (pos2 < 16) ? w[4'(15 - pos2)] : 1'b1;
      if (ws2 != chan2) begin
        chan2 = ws2;
        pos2  = 0;
      end else begin
        pos2++;
      end
    end
    prevSck2 = sck2;
  end

  always @(negedge clk) begin : monitor1
    logic [47:0] e;
    if (rst_n) begin
      if (ovr1) ovrCnt1++;
      if (valid1 && ready1) begin
        acc1.push_back(cyc);
        if (sb1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame1: got unexpected frame %h/%h expected none", left1, right1);
        end else begin
          e = sb1.pop_front();
          checkOutput("frame1 left", left1, e[47:24]);
          checkOutput("frame1 right", right1, e[23:0]);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor2
    logic [31:0] e;
    if (rst_n) begin
      if (ovr2) ovrCnt2++;
      if (valid2 && ready2) begin
        if (sb2.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame2: got unexpected frame %h/%h expected none", left2, right2);
        end else begin
          e = sb2.pop_front();
          checkOutput("frame2 left", left2, e[31:16]);
          checkOutput("frame2 right", right2, e[15:0]);
        end
      end
    end
  end

  initial begin
    int   c0, t, rc;
    bit   seen, toggled;
    logic prevS;
    rst_n  = 1'b0;
    en1    = 1'b0;
    ready1 = 1'b1;
    en2    = 1'b0;
    ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero1("reset");
    checkOutput("reset valid2", valid2, 0);
    checkOutput("reset busy2", busy2, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Start-up timing and the discarded SYNC frame
    en1 = 1'b1;
    c0  = cyc;
    waitSig(0, 1'b1, 50, "first sck rise");
    checkOutput("first rise latency", cyc - c0 - 1, 8);
    t = cyc;
    waitSig(0, 1'b0, 20, "sck fall");
    waitSig(0, 1'b1, 20, "sck rise");
    checkOutput("sck period", cyc - t, 8);
    checkOutput("busy in sync", busy1, 1);
    applyStimulus(24'hA5C3F1, 24'h5A3C0F, 1'b1);
    checkOutput("ws first rise", wsRise1 - c0 - 1, 252);
    checkOutput("ws slot length", wsFall1 - wsRise1, 256);

    // Streaming with ready held high
    applyStimulus(24'h123456, 24'hABCDEF, 1'b1);
    applyStimulus(24'hA5C3F1, 24'h5A3C0F, 1'b1);
    applyStimulus(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    checkOutput("accepted count", acc1.size(), 3);
    checkOutput("first valid latency", acc1[0] - c0 - 1, 960);
    checkOutput("valid spacing", acc1[$] - acc1[$-1], 512);

    // Overwrite: two publishes without acceptance
    ready1 = 1'b0;
    applyStimulus(24'h13579B, 24'h2468AC, 1'b1);
    applyStimulus(24'h800001, 24'h7FFFFE, 1'b1);
    checkOutput("ovr count", ovrCnt1, 1);
    checkOutput("valid held", valid1, 1);
    checkOutput("held left", left1, 24'h13579B);
    checkOutput("held right", right1, 24'h2468AC);
    @(posedge clk);
    #1 ready1 = 1'b1;

    // Enable dropped at bit 10: frame finishes and publishes, then idle
    applyStimulus(24'hC0FFEE, 24'hBADA55, 1'b1);
    repeat (90) @(posedge clk);
    #1 en1 = 1'b0;
    seen  = 1'b0;
    prevS = sck1;
    for (int i = 0; i < 700 && !seen; i++) begin
      prevS = sck1;
      @(negedge clk);
      if (!busy1) seen = 1'b1;
    end
    checkOutput("stop reached idle", seen, 1);
    checkOutput("sck high before idle", prevS, 1);
    checkOutput("sck low in idle", sck1, 0);
    checkOutput("ws low in idle", ws1, 0);
    checkOutput("stop frame delivered", sb1.size(), 0);
    toggled = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (sck1 || busy1) toggled = 1'b1;
    end
    checkOutput("idle quiet", toggled, 0);

    // Asynchronous reset in the middle of a right slot
    @(posedge clk);
    #1 en1 = 1'b1;
    applyStimulus(24'h111111, 24'h222222, 1'b1);
    waitSig(1, 1'b1, 600, "right slot");
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkAllZero1("async reset");
    sb1.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rc = cyc;
    applyStimulus(24'hDEADBE, 24'hEF0123, 1'b1);
    for (int i = 0; i < 700 && sb1.size() != 0; i++) @(negedge clk);
    checkOutput("post-reset frame delivered", sb1.size(), 0);
    checkOutput("post-reset valid latency", acc1[$] - rc - 1, 960);
    @(posedge clk);
    #1 en1 = 1'b0;

    // Instance 2: publish coinciding with acceptance
    en2 = 1'b1;
    applyStimulus2(16'hBEEF, 16'h1234, 1'b1);
    applyStimulus2(16'hCAFE, 16'h5678, 1'b1);
    waitSig(5, 1'b1, 300, "valid2 first publish");
    repeat (127) @(posedge clk);
    #1 ready2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("coincide valid", valid2, 1);
    checkOutput("coincide left", left2, 16'hCAFE);
    checkOutput("coincide right", right2, 16'h5678);
    checkOutput("coincide ovr", ovr2, 0);
    @(negedge clk);
    checkOutput("valid2 cleared", valid2, 0);
    #1 en2 = 1'b0;

    repeat (10) @(posedge clk);
    checkOutput("ovr1 total", ovrCnt1, 1);
    checkOutput("ovr2 total", ovrCnt2, 0);
    checkOutput("sb1 empty", sb1.size(), 0);
    checkOutput("sb2 empty", sb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
